amo_reservation_unit: RTL and testbench
=======================================

AMO_RESERVATION_UNIT -- requirements
Module: amo_reservation_unit

Interface
REQ-001 SHALL have parameter RESERVATION_TIMEOUT, default 64, meaning cycles a reservation survives without a matching SC.
REQ-002 SHALL have parameter GRANULE_BITS, default 2, meaning low address bits ignored in reservation compares (word granule).
REQ-003 SHALL have port clk input 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n input 1, reset that is synchronous and active-low.
REQ-005 SHALL have port lr_valid input 1, meaning an LR is issued this cycle.
REQ-006 SHALL have port lr_addr input 32, meaning the LR byte address.
REQ-007 SHALL have port sc_valid input 1, meaning an SC requests a success decision this cycle.
REQ-008 SHALL have port sc_addr input 32, meaning the SC byte address.
REQ-009 SHALL have port sc_id input id_t, meaning the SC instruction ID.
REQ-010 SHALL have port snoop_valid input 1, meaning a committed store or external write is reported.
REQ-011 SHALL have port snoop_addr input 32, meaning the write address.
REQ-012 SHALL have port flush input 1, meaning exception, xRET or context switch; kills the reservation.
REQ-013 SHALL have port sc_result_valid output 1, meaning the SC decision is presented.
REQ-014 SHALL have port sc_success output 1, meaning the store may proceed (rd=0); 0 means fail (rd=1).
REQ-015 SHALL have port sc_result_id output id_t, meaning the echoed sc_id.
REQ-016 SHALL have port reservation_valid output 1, meaning a reservation is currently held.
REQ-017 SHALL have port reservation_addr output 32-GRANULE_BITS, meaning the reserved granule.

Function
REQ-018 SHALL implement states IDLE and RESERVED; reservation_valid = (state==RESERVED).
REQ-019 SHALL, on lr_valid, capture lr_addr[31:GRANULE_BITS], load the timer with RESERVATION_TIMEOUT-1, and enter RESERVED next cycle, including when already RESERVED (re-reserve, timer reload).
REQ-020 SHALL present sc_result_valid exactly 1 cycle after sc_valid with sc_result_id = registered sc_id; SC accepted every cycle, no back-pressure.
REQ-021 SHALL compute sc_success from pre-edge state: RESERVED, granule match, and no same-cycle snoop hit or flush.
REQ-022 SHALL return to IDLE after any SC, pass or fail, unless lr_valid is asserted in the same cycle.
REQ-023 SHALL, on a snoop granule match while RESERVED, return to IDLE; a non-matching snoop has no effect.
REQ-024 SHALL decrement the timer each RESERVED cycle and return to IDLE when it reaches 0 and the cycle has no lr_valid.
REQ-025 SHALL treat simultaneous LR and SC as SC judged on old state, then LR establishes the new reservation.
REQ-026 SHALL treat simultaneous LR and snoop hit on the LR granule as the LR winning.
REQ-027 SHALL treat flush as overriding all: state becomes IDLE, and a same-cycle SC reports failure; a same-cycle LR is discarded.
REQ-028 SHALL keep sc_result_valid from depending combinationally on any input.

Reset
REQ-029 SHALL, with rst_n low at a clock edge, set state IDLE, timer 0, sc_result_valid 0, sc_success 0, sc_result_id 0, reservation_addr 0.
REQ-030 SHALL, on reset asserted mid-operation, drop a pending SC result, with no sc_result_valid in the cycle after reset.

Structure
REQ-031 SHALL have RESERVATION_TIMEOUT defined as a constant in cva5_config; reservation_state_t (IDLE, RESERVED) declared in cva5_types; id_t taken from cva5_types.
REQ-032 SHALL need no sub-module; the timer is an inline $clog2(RESERVATION_TIMEOUT)-bit down-counter.

Verification
REQ-033 SHALL cover basic pass: LR 0x1000 at t0, SC 0x1000 id=3 at t5 -> t6 sc_result_valid=1, sc_success=1, id=3; reservation_valid=0 at t7.
REQ-034 SHALL cover granule: LR 0x1000, SC 0x1002 -> success; SC 0x1004 after fresh LR 0x1000 -> fail.
REQ-035 SHALL cover snoop: LR 0x2000; snoop 0x2003 at t2; SC 0x2000 at t4 -> fail. Snoop 0x2004 instead -> pass.
REQ-036 SHALL cover timeout (RESERVATION_TIMEOUT=64): LR at t0; SC at t64 -> pass; SC at t65 -> fail.
REQ-037 SHALL cover collisions: SC+LR same cycle with no prior reservation -> fail, reservation_valid=1 next cycle; SC+flush -> fail; LR+flush -> reservation_valid=0.
REQ-038 SHALL cover reset: LR, then rst_n low one cycle while an SC is in flight -> no sc_result_valid, reservation_valid=0.

Source files
------------

// File: rtl/cva5_config.sv
// Core-wide configuration constants shared by the CVA5 memory pipeline blocks.
package cva5_config;
   localparam int RESERVATION_TIMEOUT = 64;
endpackage

// File: rtl/cva5_types.sv
// Core-wide shared types used by the CVA5 memory pipeline blocks.
package cva5_types;
   localparam int ID_W = 4;

   typedef logic [ID_W-1:0] id_t;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      RESERVED = 1'b1
   } reservation_state_t;
endpackage

// File: rtl/amo_reservation_unit.sv
// LR/SC reservation tracker: holds one granule reservation, judges SCs against it,
// and drops it on snoop hit, flush, SC or timeout.
module amo_reservation_unit
   import cva5_types::*;
#(
   parameter int RESERVATION_TIMEOUT = cva5_config::RESERVATION_TIMEOUT,
   parameter int GRANULE_BITS        = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     lr_valid,
   input  logic [31:0]              lr_addr,
   input  logic                     sc_valid,
   input  logic [31:0]              sc_addr,
   input  id_t                      sc_id,
   input  logic                     snoop_valid,
   input  logic [31:0]              snoop_addr,
   input  logic                     flush,
   output logic                     sc_result_valid,
   output logic                     sc_success,
   output id_t                      sc_result_id,
   output logic                     reservation_valid,
   output logic [31-GRANULE_BITS:0] reservation_addr
);
   localparam int TIMER_W = (RESERVATION_TIMEOUT > 1) ? $clog2(RESERVATION_TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(RESERVATION_TIMEOUT - 1);

   reservation_state_t        state_r;
   reservation_state_t        state_nxt_s;
   logic [TIMER_W-1:0]        timer_r;
   logic [TIMER_W-1:0]        timer_nxt_s;
   logic [31-GRANULE_BITS:0]  res_addr_r;
   logic [31-GRANULE_BITS:0]  res_addr_nxt_s;
   logic                      sc_result_valid_r;
   logic                      sc_success_r;
   id_t                       sc_result_id_r;
   logic                      reserved_s;
   logic                      snoop_hit_s;
   logic                      sc_pass_s;
   logic                      unused_s;

   assign unused_s = ^{lr_addr[GRANULE_BITS-1:0], sc_addr[GRANULE_BITS-1:0],
                       snoop_addr[GRANULE_BITS-1:0]};

   // SC decision uses only the state held before this edge
   assign reserved_s  = (state_r == RESERVED);
   assign snoop_hit_s = snoop_valid && reserved_s && (snoop_addr[31:GRANULE_BITS] == res_addr_r);
   assign sc_pass_s   = sc_valid && reserved_s && (sc_addr[31:GRANULE_BITS] == res_addr_r)
                        && !snoop_hit_s && !flush;

   // Next reservation state: flush beats LR, LR beats SC/snoop/timeout
   always_comb begin
      state_nxt_s    = state_r;
      timer_nxt_s    = timer_r;
      res_addr_nxt_s = res_addr_r;
      if (flush) begin
         state_nxt_s = IDLE;
         timer_nxt_s = {TIMER_W{1'b0}};
      end else if (lr_valid) begin
         state_nxt_s    = RESERVED;
         timer_nxt_s    = TIMER_LOAD;
         res_addr_nxt_s = lr_addr[31:GRANULE_BITS];
      end else begin
         case (state_r)
            RESERVED: begin
               if (sc_valid || snoop_hit_s || (timer_r == {TIMER_W{1'b0}})) begin
                  state_nxt_s = IDLE;
                  timer_nxt_s = {TIMER_W{1'b0}};
               end else begin
                  timer_nxt_s = timer_r - TIMER_W'(1);
               end
            end
            default: begin
               state_nxt_s = IDLE;
               timer_nxt_s = {TIMER_W{1'b0}};
            end
         endcase
      end
   end

   // Reservation state, timer and reserved granule
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         timer_r    <= {TIMER_W{1'b0}};
         res_addr_r <= {(32-GRANULE_BITS){1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         timer_r    <= timer_nxt_s;
         res_addr_r <= res_addr_nxt_s;
      end
   end

   // SC result pipeline stage, one cycle after the request
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sc_result_valid_r <= 1'b0;
         sc_success_r      <= 1'b0;
         sc_result_id_r    <= '0;
      end else begin
         sc_result_valid_r <= sc_valid;
         sc_success_r      <= sc_pass_s;
         if (sc_valid) begin
            sc_result_id_r <= sc_id;
         end else begin
            sc_result_id_r <= sc_result_id_r;
         end
      end
   end

   assign sc_result_valid   = sc_result_valid_r;
   assign sc_success        = sc_success_r;
   assign sc_result_id      = sc_result_id_r;
   assign reservation_valid = reserved_s;
   assign reservation_addr  = res_addr_r;
endmodule

// File: tb/tb_amo_reservation_unit.sv
// Self-checking bench: directed LR/SC scenarios plus random traffic against a
// deadline-based reservation model.
module tb_amo_reservation_unit;
   import cva5_types::*;

   localparam int TO = 64;
   localparam int GB = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         lr_valid;
   logic [31:0]  lr_addr;
   logic         sc_valid;
   logic [31:0]  sc_addr;
   id_t          sc_id;
   logic         snoop_valid;
   logic [31:0]  snoop_addr;
   logic         flush;
   logic         sc_result_valid;
   logic         sc_success;
   id_t          sc_result_id;
   logic         reservation_valid;
   logic [31-GB:0] reservation_addr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model: a reservation is alive through cycle m_deadline
   bit          m_valid = 1'b0;
   logic [29:0] m_gran  = '0;
   int          m_deadline = 0;
   bit          e_rv = 1'b0;
   bit          e_succ = 1'b0;
   id_t         e_id = '0;

   amo_reservation_unit #(.RESERVATION_TIMEOUT(TO), .GRANULE_BITS(GB)) dut (
      .clk(clk), .rst_n(rst_n), .lr_valid(lr_valid), .lr_addr(lr_addr),
      .sc_valid(sc_valid), .sc_addr(sc_addr), .sc_id(sc_id),
      .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .flush(flush),
      .sc_result_valid(sc_result_valid), .sc_success(sc_success),
      .sc_result_id(sc_result_id), .reservation_valid(reservation_valid),
      .reservation_addr(reservation_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input logic r, input logic l, input logic [31:0] la,
                       input logic s, input logic [31:0] sa, input id_t si,
                       input logic sn, input logic [31:0] sna, input logic f);
      bit alive;
      bit hit;
      @(negedge clk);
      rst_n = r; lr_valid = l; lr_addr = la; sc_valid = s; sc_addr = sa; sc_id = si;
      snoop_valid = sn; snoop_addr = sna; flush = f;
      alive = m_valid && (cyc <= m_deadline);
      hit   = sn && alive && (sna[31:GB] == m_gran);
      if (!r) begin
         m_valid = 1'b0; m_gran = '0; e_rv = 1'b0; e_succ = 1'b0; e_id = '0;
      end else begin
         e_rv   = s;
         e_succ = s && alive && (sa[31:GB] == m_gran) && !hit && !f;
         if (s) e_id = si;
         if (f) m_valid = 1'b0;
         else if (l) begin
            m_valid = 1'b1; m_gran = la[31:GB]; m_deadline = cyc + TO;
         end else if (!alive || s || hit) m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("result_valid", {31'd0, sc_result_valid}, {31'd0, e_rv});
      chk("success", {31'd0, sc_success}, {31'd0, e_succ});
      chk("result_id", {28'd0, sc_result_id}, {28'd0, e_id});
      chk("res_valid", {31'd0, reservation_valid}, {31'd0, m_valid && (cyc <= m_deadline)});
      chk("res_addr", {2'd0, reservation_addr}, {2'd0, m_gran});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
   endtask
   task automatic lr(input logic [31:0] a);
      step(1'b1, 1'b1, a, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
   endtask
   task automatic sc(input logic [31:0] a, input id_t id);
      step(1'b1, 1'b0, 32'd0, 1'b1, a, id, 1'b0, 32'd0, 1'b0);
   endtask
   task automatic snoop(input logic [31:0] a);
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1, a, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; lr_valid = 1'b0; lr_addr = 32'd0; sc_valid = 1'b0; sc_addr = 32'd0;
      sc_id = '0; snoop_valid = 1'b0; snoop_addr = 32'd0; flush = 1'b0;
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0);
      chk("reset_res_valid", {31'd0, reservation_valid}, 32'd0);
      chk("reset_id", {28'd0, sc_result_id}, 32'd0);

      // basic pass: LR t0, SC t5
      lr(32'h1000); idle(4); sc(32'h1000, 4'd3);
      chk("basic_succ", {31'd0, sc_success}, 32'd1);
      chk("basic_id", {28'd0, sc_result_id}, 32'd3);
      idle(1);
      chk("basic_released", {31'd0, reservation_valid}, 32'd0);

      // granule match and mismatch
      lr(32'h1000); sc(32'h1002, 4'd1);
      chk("gran_same", {31'd0, sc_success}, 32'd1);
      lr(32'h1000); sc(32'h1004, 4'd2);
      chk("gran_other", {31'd0, sc_success}, 32'd0);

      // snoop hit kills, neighbour snoop does not
      lr(32'h2000); idle(1); snoop(32'h2003); idle(1); sc(32'h2000, 4'd4);
      chk("snoop_hit", {31'd0, sc_success}, 32'd0);
      lr(32'h2000); idle(1); snoop(32'h2004); idle(1); sc(32'h2000, 4'd5);
      chk("snoop_miss", {31'd0, sc_success}, 32'd1);

      // timeout edge: SC at t64 passes, at t65 fails
      lr(32'h3000); idle(63); sc(32'h3000, 4'd6);
      chk("timeout_t64", {31'd0, sc_success}, 32'd1);
      lr(32'h3000); idle(64); sc(32'h3000, 4'd7);
      chk("timeout_t65", {31'd0, sc_success}, 32'd0);

      // collisions
      step(1'b1, 1'b1, 32'h4000, 1'b1, 32'h4000, 4'd8, 1'b0, 32'd0, 1'b0);
      chk("sc_lr_fail", {31'd0, sc_success}, 32'd0);
      chk("sc_lr_resv", {31'd0, reservation_valid}, 32'd1);
      step(1'b1, 1'b0, 32'd0, 1'b1, 32'h4000, 4'd9, 1'b0, 32'd0, 1'b1);
      chk("sc_flush", {31'd0, sc_success}, 32'd0);
      step(1'b1, 1'b1, 32'h5000, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b1);
      chk("lr_flush", {31'd0, reservation_valid}, 32'd0);
      lr(32'h6000); step(1'b1, 1'b1, 32'h7000, 1'b0, 32'd0, 4'd0, 1'b1, 32'h7001, 1'b0);
      chk("lr_snoop", {31'd0, reservation_valid}, 32'd1);

      // reset while SC in flight
      lr(32'h8000);
      step(1'b0, 1'b0, 32'd0, 1'b1, 32'h8000, 4'd10, 1'b0, 32'd0, 1'b0);
      chk("rst_no_result", {31'd0, sc_result_valid}, 32'd0);
      chk("rst_res_valid", {31'd0, reservation_valid}, 32'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] base;
         logic [31:0] a0;
         logic [31:0] a1;
         logic [31:0] a2;
         base = ($urandom_range(1) == 0) ? 32'h1000 : 32'h2000;
         a0 = base + 32'($urandom_range(7));
         a1 = base + 32'($urandom_range(7));
         a2 = base + 32'($urandom_range(7));
         step(($urandom_range(199) != 0), ($urandom_range(5) == 0), a0,
              ($urandom_range(4) == 0), a1, id_t'($urandom),
              ($urandom_range(9) == 0), a2, ($urandom_range(29) == 0));
      end
      for (int i = 0; i < 3; i++) begin
         lr(32'h9000);
         idle(TO - 2 + i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
